// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one physical-memory line port between the
// prefetcher (read-only) and the data cache (read/write).  One request is
// granted at a time.  The memory handshake is held until pmem_resp, a
// one-cycle response goes back to the granted requester, and then one idle
// recovery cycle follows before the next grant.
//
// Optional build macro ARB_ROUND_ROBIN_EN: when both requesters ask in the
// same IDLE cycle, grant the one not served most recently.  When the macro is
// undefined, the data cache always wins a tie.
module line_mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   // prefetcher line-read port
   input  logic                  pre_read_a,
   input  logic [ADDR_WIDTH-1:0] pre_addr_a,
   output logic [LINE_WIDTH-1:0] arb_pre_rdata,
   output logic                  arb_pre_resp,
   // data cache line port
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   // physical memory line port
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [2:0] {
      IDLE,
      SERVE_PRE,
      SERVE_D,
      RESP,
      RECOVER
   } state_t;

   // Clears the in-line byte offset; pure masking, so no carry can occur.
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;         // line-aligned issue address
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;       // latched write line
   logic                  write_q, write_d;       // latched op: 1 = write
   logic                  sel_d_q, sel_d_d;       // granted port: 1 = data cache
   logic [LINE_WIDTH-1:0] pre_rdata_q, pre_rdata_d;
   logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

   logic d_req;
   logic grant_d;
   logic grant_pre;

   // A simultaneous read+write from the data cache is handled as a write.
   assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;  // 1 = data cache was granted most recently

   // Tie-break toward the port not served last; a lone requester always wins.
   always_comb begin
      grant_d  = d_req;
      last_d_d = last_d_q;
      if (d_req && pre_read_a) begin
         grant_d = ~last_d_q;
      end
      if ((state_q == IDLE) && (d_req || pre_read_a)) begin
         last_d_d = grant_d;
      end
   end

   // Last-granted flag; it starts as though the data cache was just served.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_d_q <= 1'b1;
      end else begin
         last_d_q <= last_d_d;
      end
   end
`else
   // Fixed priority: the data cache always wins a tie.
   always_comb begin
      grant_d = d_req;
   end
`endif

   assign grant_pre = pre_read_a & ~grant_d;

   // Next-state logic: sample requests only in IDLE and capture memory data on pmem_resp.
   always_comb begin
      // NOTE: every signal gets a default before the case. A path that leaves
      // one unassigned would infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      sel_d_d     = sel_d_q;
      pre_rdata_d = pre_rdata_q;
      d_rdata_d   = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = SERVE_D;
               addr_d  = d_addr & LINE_MASK;
               write_d = d_write;
               sel_d_d = 1'b1;
               if (d_write) begin
                  wdata_d = d_wdata;
               end
            end else if (grant_pre) begin
               state_d = SERVE_PRE;
               addr_d  = pre_addr_a & LINE_MASK;
               write_d = 1'b0;
               sel_d_d = 1'b0;
            end
         end
         SERVE_PRE: begin
            if (pmem_resp) begin
               pre_rdata_d = pmem_rdata;
               state_d     = RESP;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               if (!write_q) begin
                  d_rdata_d = pmem_rdata;
               end
               state_d = RESP;
            end
         end
         RESP:    state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset clears every register, including the returned line data.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments here, so each register reads the
      // previous-cycle value of the others regardless of statement order.
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         sel_d_q     <= 1'b0;
         pre_rdata_q <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         sel_d_q     <= sel_d_d;
         pre_rdata_q <= pre_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // Outputs decode directly from registered state, so reset clears them immediately.
   always_comb begin
      pmem_read     = (state_q == SERVE_PRE) || ((state_q == SERVE_D) && !write_q);
      pmem_write    = (state_q == SERVE_D) && write_q;
      pmem_address  = addr_q;
      pmem_wdata    = wdata_q;
      arb_pre_resp  = (state_q == RESP) && !sel_d_q;
      d_resp        = (state_q == RESP) && sel_d_q;
      arb_pre_rdata = pre_rdata_q;
      d_rdata       = d_rdata_q;
   end

endmodule
